// File: rtl/mac_rr_arbiter_if.sv
// Request/result bundle between NREQ producers and the shared multiply-add arbiter.
// Operands are packed per requester: requester i occupies bits [i*W +: W].
interface mac_rr_arbiter_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_c;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [2*W-1:0]    res_data;
  logic [IDW-1:0]    res_id;

  modport master (
    output req_valid, req_a, req_b, req_c,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter feeding a 3-stage unsigned a*b+c pipeline; results carry the
// originating requester id and leave in acceptance order at a fixed latency.
module mac_rr_arbiter #(
  parameter int unsigned par  = 7,
  parameter int unsigned NREQ = 4
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic             i_en,
  mac_rr_arbiter_if.slave io_bus
);
  localparam int unsigned W   = par + 1;
  localparam int unsigned RW  = 2 * W;
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  r_last_grant;
  logic [NREQ-1:0] w_ready;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_grant_vld;
  logic [W-1:0]    w_a, w_b, w_c;

  logic [W-1:0]    r_a1, r_b1, r_c1;
  logic [IDW-1:0]  r_id1, r_id2, r_id3;
  logic            r_v1, r_v2, r_v3;
  logic [RW-1:0]   r_p2, r_s3;
  logic [W-1:0]    r_c2;

  // Search starts one past the last grant so every waiting requester is served
  // within NREQ-1 grants of others.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_ready     = '0;
    w_grant_idx = '0;
    w_grant_vld = 1'b0;
    v_idx       = '0;
    if (i_en && !i_reset) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        v_idx = IDW'((int'(r_last_grant) + k) % NREQ);
        if (!w_grant_vld && io_bus.req_valid[v_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = v_idx;
        end
      end
      if (w_grant_vld) w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_a = io_bus.req_a[int'(w_grant_idx) * W +: W];
  assign w_b = io_bus.req_b[int'(w_grant_idx) * W +: W];
  assign w_c = io_bus.req_c[int'(w_grant_idx) * W +: W];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_a1  <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
      r_id1 <= '0;
      r_v1  <= 1'b0;
      r_p2  <= '0;
      r_c2  <= '0;
      r_id2 <= '0;
      r_v2  <= 1'b0;
      r_s3  <= '0;
      r_id3 <= '0;
      r_v3  <= 1'b0;
    end else if (i_en) begin
      if (w_grant_vld) r_last_grant <= w_grant_idx;
      r_a1  <= w_a;
      r_b1  <= w_b;
      r_c1  <= w_c;
      r_id1 <= w_grant_idx;
      r_v1  <= w_grant_vld;
      r_p2  <= RW'(r_a1) * RW'(r_b1);
      r_c2  <= r_c1;
      r_id2 <= r_id1;
      r_v2  <= r_v1;
      r_s3  <= r_p2 + RW'(r_c2);
      r_id3 <= r_id2;
      r_v3  <= r_v2;
    end
  end

  // Gating with en reports each result exactly once, in the cycle it leaves S3.
  assign io_bus.req_ready = w_ready;
  assign io_bus.res_valid = r_v3 & i_en & ~i_reset;
  assign io_bus.res_data  = i_reset ? '0 : r_s3;
  assign io_bus.res_id    = i_reset ? '0 : r_id3;
endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Scoreboard bench for mac_rr_arbiter: a reference arbiter predicts grants and queues
// expected results; an independent monitor pops and compares every res_valid.
module tb_mac_rr_arbiter;
  localparam int unsigned PAR  = 7;
  localparam int unsigned W    = PAR + 1;
  localparam int unsigned NREQ = 4;

  typedef struct {
    longint data;
    int     id;
    int     acc;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  logic en;
  always #5 clk = ~clk;

  mac_rr_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  mac_rr_arbiter #(.par(PAR), .NREQ(NREQ)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (en),
    .io_bus  (bus)
  );

  int    errors = 0;
  int    checks = 0;
  int    ecnt   = 0;
  int    nres   = 0;
  int    mdl_last = NREQ - 1;
  int    waits[NREQ];
  item_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) if (!reset && en) ecnt <= ecnt + 1;

  // Reference arbiter and scoreboard push.
  always @(negedge clk) begin
    int g;
    longint ea, eb, ec;
    logic [NREQ-1:0] exp_ready;
    if (reset) begin
      chk("ready_in_reset", bus.req_ready, 0);
      chk("res_valid_in_reset", bus.res_valid, 0);
      chk("res_data_in_reset", bus.res_data, 0);
      chk("res_id_in_reset", bus.res_id, 0);
      mdl_last = NREQ - 1;
      sb.delete();
      foreach (waits[i]) waits[i] = 0;
    end else if (!en) begin
      chk("ready_stall", bus.req_ready, 0);
      chk("res_valid_stall", bus.res_valid, 0);
    end else begin
      g = rr_pick(bus.req_valid, mdl_last);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", bus.req_ready, exp_ready);
      if (g >= 0) begin
        ea = longint'(bus.req_a[g*W +: W]);
        eb = longint'(bus.req_b[g*W +: W]);
        ec = longint'(bus.req_c[g*W +: W]);
        sb.push_back('{data: ea * eb + ec, id: g, acc: ecnt});
        mdl_last = g;
        for (int i = 0; i < NREQ; i++) begin
          if (i == g || !bus.req_valid[i]) waits[i] = 0;
          else begin
            waits[i]++;
            chk("fairness_wait_ok", waits[i] <= NREQ - 1, 1);
          end
        end
      end
    end
  end

  // Monitor: every result must match the oldest outstanding request.
  always @(negedge clk) begin
    item_t it;
    if (bus.res_valid) begin
      nres++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        it = sb.pop_front();
        chk("res_data", bus.res_data, it.data);
        chk("res_id", bus.res_id, it.id);
        chk("latency", ecnt - it.acc, 3);
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int c);
    bus.req_valid[i]     = 1'b1;
    bus.req_a[i*W +: W]  = W'(a);
    bus.req_b[i*W +: W]  = W'(b);
    bus.req_c[i*W +: W]  = W'(c);
  endtask

  // One clock; accepted requests drop their valid unless the caller re-raises it.
  task automatic tick();
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Single request from requester 1: 3*5+7 = 22.
    set_req(1, 3, 5, 7);
    repeat (6) tick();

    // All requesters continuously valid: grants rotate 0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 2, 0);
    repeat (12) begin
      tick();
      bus.req_valid = '1;
    end
    bus.req_valid = '0;
    repeat (4) tick();

    // Largest operands: 255*255+255 = 65280.
    set_req(2, 255, 255, 255);
    repeat (5) tick();

    // Stall for 2 cycles with requests in flight.
    for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 3 + i, i);
    repeat (3) begin
      tick();
      bus.req_valid = '1;
    end
    en = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    repeat (3) begin
      tick();
      bus.req_valid = '1;
    end
    bus.req_valid = '0;
    repeat (6) tick();

    // Reset pulse with work in flight; requesters 0 and 3 waiting across it.
    set_req(1, 7, 7, 1);
    set_req(2, 9, 4, 2);
    repeat (3) begin
      tick();
      bus.req_valid[1] = 1'b1;
      bus.req_valid[2] = 1'b1;
    end
    bus.req_valid = '0;
    set_req(0, 11, 12, 13);
    set_req(3, 21, 22, 23);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();

    // Random traffic with occasional stalls.
    for (int n = 0; n < 10000; n++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) != 0)
          set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
      tick();
    end

    en = 1'b1;
    bus.req_valid = '0;
    repeat (8) tick();
    chk("scoreboard_drained", sb.size(), 0);
    chk("results_seen", nres > 1000, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_rr_arbiter.md
# mac_rr_arbiter

Shares one pipelined unsigned multiply-add unit (res = a*b + c) between NREQ requesters. A round-robin arbiter grants at most one request per cycle, issues it into a 3-stage registered datapath, and tags it so the result is returned with the id of its originator. The block sits between several producer blocks and the single MAC resource, giving one issue per cycle and fixed latency.

## Interface
- par, default 7: MSB index of operands; operand width W = par+1, result width 2W = par*2+2.
- NREQ, default 4: number of requesters (2..8); id width IDW = clog2(NREQ).
- clk, input, 1: clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: global advance enable; 0 freezes the arbiter and pipeline.
- req_valid, input, NREQ: per-requester request.
- req_a, input, NREQ*W: operand a; requester i at bits [i*W +: W].
- req_b, input, NREQ*W: operand b, same packing.
- req_c, input, NREQ*W: addend c, same packing.
- req_ready, output, NREQ: one-hot-or-zero grant; a request is accepted at a rising edge where req_valid[i] & req_ready[i].
- res_valid, output, 1: result strobe, high for exactly one cycle per accepted request.
- res_data, output, 2W: a*b + c of that request.
- res_id, output, IDW: index of the originating requester.

## Operation
- Arbiter: pointer last_grant (IDW bits). Each cycle with en=1, req_ready asserts for the first i with req_valid[i]=1, searching last_grant+1, +2, … modulo NREQ. No valid request: req_ready = 0, last_grant unchanged.
- req_ready is combinational from req_valid, last_grant and en; req_ready = 0 whenever en=0 or reset=1.
- On acceptance, last_grant <= granted index.
- Requester rule: once req_valid[i] rises, it and that requester's operands stay stable until accepted. A request is never dropped or duplicated.
- Pipeline, all stages advancing only when en=1:
  - S1 captures a, b, c, id and v1=1 of the accepted request; v1=0 if none.
  - S2: p = a1*b1 (2W bits), c2, id2, v2.
  - S3: s = p + zero-extended c2, id3, v3.
- Arithmetic: unsigned. The maximum (2^W-1)^2 + (2^W-1) = 2^2W - 2^W fits in 2W bits, so there is no overflow or truncation.
- Outputs: res_valid = v3 & en, res_data = s, res_id = id3. Gating with en guarantees each result is reported once, in the cycle it leaves S3.
- No result backpressure: the consumer samples res_* whenever res_valid=1.
- en=0: all registers (last_grant, S1..S3) hold, no grant, res_valid=0. Operation resumes unchanged when en returns to 1.

## Timing
- Reset (synchronous, dominates en): v1=v2=v3=0, a/b/c/p/s/id registers = 0, last_grant = NREQ-1, so requester 0 has top priority at the first arbitration.
- Output values during and after reset: req_ready=0 while reset=1; res_valid=0, res_data=0, res_id=0.
- Reset mid-operation: all in-flight requests are discarded, with no res_valid for them. Requesters whose requests were not accepted keep req_valid and are re-arbitrated.
- Latency: request accepted at edge N (cycles counted with en=1) -> res_valid=1 in the cycle following edge N+2, i.e. 3 cycles after the handshake cycle. Each stalled cycle adds 1.
- Throughput: 1 accept and 1 result per enabled cycle. Results emerge in acceptance order.
- Simultaneous events: the grant and result strobe of different requests in one cycle are independent. The same requester may be granted again immediately only if no other requester is valid.

## Test plan
- After reset, only requester 1 valid with a=3, b=5, c=7 -> req_ready=4'b0010 in the same cycle; 3 cycles later res_valid=1, res_data=22, res_id=1, for one cycle.
- All 4 requesters valid continuously, requester i with a=i+1, b=2, c=0 -> grants 0,1,2,3,0,… each cycle; results 2,4,6,8,2,… back-to-back with res_id 0,1,2,3,0.
- Requester 2 with a=b=c=255 (par=7) -> res_data=65280, res_id=2; checks no overflow.
- Stream with en driven low for 2 cycles while 3 requests are in flight -> no grants and res_valid=0 during the stall. After en=1 the remaining results appear in order, each exactly once, with latency extended by 2.
- Reset pulse for 1 cycle with 3 requests in flight and requesters 0 and 3 waiting -> no res_valid for the in-flight requests. The first grant after reset goes to requester 0, then requester 3.
- Random traffic on 4 requesters for 10,000 cycles against a reference model -> every accepted request produces exactly one correct result with the correct id. No requester waits more than NREQ-1 grants while valid.
